temperature_reader: RTL

TEMPERATURE_READER -- requirements
Module: temperature_reader

---
 rtl/temperature_reader_if.sv | 31 +++
 rtl/temperature_reader.sv | 138 +++++++++++++
 2 files changed

// File: rtl/temperature_reader_if.sv
// Sensor SPI pins and conversion result bus of the temperature reader.
// The master side is the reader; the slave side is the sensor/consumer.
interface temperature_reader_if;
  logic        ocs_n;
  logic        osck;
  logic        ispi_miso;
  logic [15:0] otemperature;
  logic        ovalid;
  logic        ofault;
  logic        obusy;

  modport master (
    output ocs_n,
    output osck,
    input  ispi_miso,
    output otemperature,
    output ovalid,
    output ofault,
    output obusy
  );

  modport slave (
    input  ocs_n,
    input  osck,
    output ispi_miso,
    input  otemperature,
    input  ovalid,
    input  ofault,
    input  obusy
  );
endinterface

// File: rtl/temperature_reader.sv
// Periodic MAX6675-format thermocouple reader with binary-to-BCD result.
// Reads a 16-bit frame, converts degrees C to 4 packed BCD digits.
module temperature_reader #(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 12_500_000
) (
  input logic                   iclock,
  input logic                   ireset,
  temperature_reader_if.master  bus
);

  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SHIFT   = 2'd1;
  localparam logic [1:0] S_CONVERT = 2'd2;
  localparam logic [1:0] S_UPDATE  = 2'd3;

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [DW-1:0] div;
  logic          phase;
  logic [3:0]    bit_cnt;
  logic [3:0]    conv_cnt;
  logic [15:0]   shreg;
  logic [9:0]    bin;
  logic [15:0]   bcd;
  logic [15:0]   adj;
  logic          fault;
  logic          tick;

  logic          cs_n;
  logic          sck;
  logic [15:0]   temp;
  logic          valid;
  logic          fault_q;
  logic          busy;

  assign tick = (timer == T_LAST);

  // add-3 correction applied to every digit before each shift
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (adj[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge iclock) begin
    if (ireset) begin
      state    <= S_IDLE;
      timer    <= '0;
      div      <= '0;
      phase    <= 1'b0;
      bit_cnt  <= '0;
      conv_cnt <= '0;
      shreg    <= '0;
      bin      <= '0;
      bcd      <= '0;
      fault    <= 1'b0;
      cs_n     <= 1'b1;
      sck      <= 1'b0;
      temp     <= '0;
      valid    <= 1'b0;
      fault_q  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      timer <= tick ? '0 : timer + 1'b1;
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick) begin
            state   <= S_SHIFT;
            cs_n    <= 1'b0;
            sck     <= 1'b0;
            div     <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (div == D_LAST) begin
            div <= '0;
            if (!phase) begin
              // sample on the cycle sck goes high
              sck   <= 1'b1;
              phase <= 1'b1;
              shreg <= {shreg[14:0], bus.ispi_miso};
            end else if (bit_cnt == 4'd15) begin
              sck      <= 1'b0;
              cs_n     <= 1'b1;
              state    <= S_CONVERT;
              bin      <= shreg[14:5];
              fault    <= shreg[2] | shreg[15];
              bcd      <= '0;
              conv_cnt <= '0;
            end else begin
              sck     <= 1'b0;
              phase   <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        S_CONVERT: begin
          bcd <= (adj << 1) | {15'd0, bin[9]};
          bin <= {bin[8:0], 1'b0};
          if (conv_cnt == 4'd9)
            state <= S_UPDATE;
          else
            conv_cnt <= conv_cnt + 1'b1;
        end
        S_UPDATE: begin
          temp    <= fault ? 16'hFFFF : bcd;
          fault_q <= fault;
          valid   <= 1'b1;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ocs_n        = cs_n;
  assign bus.osck         = sck;
  assign bus.otemperature = temp;
  assign bus.ovalid       = valid;
  assign bus.ofault       = fault_q;
  assign bus.obusy        = busy;

endmodule
